pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Front-end pipeline controller. Generates every stall, flush and redirect control for the fetch stage, the IF_ID register and the ID_EX register.
- Arbitrates between three hazard sources:
  - data-memory wait (highest priority)
  - EX-stage branch redirect
  - load-use hazard
- Holds a branch redirect that resolves during a memory wait, so it is not lost.

Parameters:
- XLEN, 64, width of PC and branch target.
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard; range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  IF_ID holds a valid instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_valid  in  1  ID_EX holds a valid instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- br_valid  in  1  EX branch/jump resolved this cycle
- br_taken  in  1  resolved branch taken
- br_target  in  XLEN  resolved target
- mem_busy  in  1  data memory not ready; whole pipe must freeze
- pc_stall  out  1  to fetch stall
- if_id_stall  out  1  to IF_ID stall
- if_id_flush  out  1  to IF_ID flush
- id_ex_stall  out  1  hold ID_EX
- id_ex_flush  out  1  insert bubble into ID_EX
- fetch_branch_taken  out  1  to fetch branch_taken
- fetch_branch_target  out  XLEN  to fetch branch_target
- stall_cycles  out  32  performance counter
- flush_events  out  32  performance counter

Behaviour:
- Reset: state=RUN, lu_cnt=0, pend_br=0, pend_target=0. While rst is high all outputs are 0.
- Decision logic is combinational from state, registers and inputs. Registers update on posedge clk. Redirect latency is 0 cycles: fetch loads the target on the same edge.
- Load-use hazard (lu_hit): ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- State RUN:
  - mem_busy=1: pc_stall=if_id_stall=id_ex_stall=1, no flush. If br_valid&br_taken, latch pend_br=1 and pend_target=br_target. Next state MEM_WAIT.
  - else if pend_br=1 or (br_valid&br_taken):
    - fetch_branch_taken=1.
    - Target is pend_target if pend_br=1, else br_target.
    - if_id_flush=1, id_ex_flush=1. Clear pend_br.
    - Any lu_hit this cycle is discarded. Stay in RUN.
  - else if lu_hit: pc_stall=if_id_stall=1, id_ex_flush=1. If LU_STALL_CYCLES>1, load lu_cnt=LU_STALL_CYCLES-1 and go to LU_STALL; otherwise stay in RUN.
  - else: all controls 0.
- State LU_STALL:
  - Outputs as for lu_hit (stall front, bubble ID_EX). lu_cnt decrements each cycle; at lu_cnt==1, next state RUN.
  - mem_busy=1: mem_busy behaviour overrides. Go to MEM_WAIT; lu_cnt is kept frozen.
  - br_valid&br_taken: redirect as in RUN, clear lu_cnt, next state RUN.
- State MEM_WAIT:
  - Full freeze (pc_stall, if_id_stall, id_ex_stall=1). No flush, no redirect.
  - br_valid&br_taken here also latches pend_br. The last one wins.
  - When mem_busy falls, next state is LU_STALL if lu_cnt!=0, else RUN. The pending redirect is then applied on the first RUN cycle, or it preempts LU_STALL.
- A stall and a flush of the same register are never asserted together. If both are requested, the flush wins and the stall is dropped.
- Reset asserted mid-operation immediately clears the pending branch and the counters.
- fetch_branch_target drives 0 whenever fetch_branch_taken=0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_stall=1.
  - flush_events increments on every cycle with if_id_flush=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, LU_STALL_CYCLES=1 -> exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1, then all 0.
- Load with ex_rd=0, or uses bits clear -> no stall.
- LU_STALL_CYCLES=3 with a single hazard pulse -> three consecutive stall cycles; a taken branch on cycle 2 -> redirect asserted, stall ends the same cycle.
- Simultaneous lu_hit and br_taken with br_target=0x1000 -> fetch_branch_taken=1, target 0x1000, if_id_flush=id_ex_flush=1, pc_stall=0.
- mem_busy held 4 cycles with br_taken at target 0x2000 on cycle 2 -> 4 cycles of full freeze and no redirect, then one cycle of fetch_branch_taken=1 with target 0x2000.
- With HAZARD_PERF_CNT_EN: the above sequence yields the exact stall_cycles and flush_events totals. Assert rst mid-MEM_WAIT -> all outputs and counters 0, no pending redirect after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard controller: stall/flush/redirect for fetch, IF_ID and ID_EX.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int XLEN            = 64,
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            mem_busy,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_stall,
  output logic            id_ex_flush,
  output logic            fetch_branch_taken,
  output logic [XLEN-1:0] fetch_branch_target,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_events
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);

  state_t            state_q, state_d, eff_state;
  logic [2:0]        lu_cnt_q, lu_cnt_d;
  logic              pend_br_q, pend_br_d;
  logic [XLEN-1:0]   pend_target_q, pend_target_d;

  logic              lu_hit, br_take;
  logic              pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic              id_ex_stall_c, id_ex_flush_c, taken_c;
  logic [XLEN-1:0]   target_c;

  assign br_take = br_valid & br_taken;
  assign lu_hit  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                    (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    pend_br_d     = pend_br_q;
    pend_target_d = pend_target_q;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_stall_c = 1'b0;
    id_ex_flush_c = 1'b0;
    taken_c       = 1'b0;
    target_c      = '0;

    // Leaving MEM_WAIT takes effect in the same cycle mem_busy drops, so the
    // resumed state's controls (redirect or load-use bubble) apply immediately.
    eff_state = state_q;
    if (state_q == MEM_WAIT && !mem_busy)
      eff_state = (lu_cnt_q != 3'd0) ? LU_STALL : RUN;

    if (mem_busy) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      id_ex_stall_c = 1'b1;
      if (br_take) begin
        pend_br_d     = 1'b1;
        pend_target_d = br_target;
      end
      state_d = MEM_WAIT;
    end else if (pend_br_q || br_take) begin
      // An older held redirect takes precedence over a newly resolved one.
      taken_c       = 1'b1;
      target_c      = pend_br_q ? pend_target_q : br_target;
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      pend_br_d     = 1'b0;
      lu_cnt_d      = 3'd0;
      state_d       = RUN;
    end else if (eff_state == LU_STALL) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      id_ex_flush_c = 1'b1;
      lu_cnt_d      = lu_cnt_q - 3'd1;
      state_d       = (lu_cnt_q == 3'd1) ? RUN : LU_STALL;
    end else if (lu_hit) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      id_ex_flush_c = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        lu_cnt_d = LU_INIT;
        state_d  = LU_STALL;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      lu_cnt_q      <= 3'd0;
      pend_br_q     <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      pend_br_q     <= pend_br_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Flush wins over stall on the same register; everything is forced low in reset.
  assign pc_stall            = pc_stall_c & ~rst;
  assign if_id_flush         = if_id_flush_c & ~rst;
  assign if_id_stall         = if_id_stall_c & ~if_id_flush_c & ~rst;
  assign id_ex_flush         = id_ex_flush_c & ~rst;
  assign id_ex_stall         = id_ex_stall_c & ~id_ex_flush_c & ~rst;
  assign fetch_branch_taken  = taken_c & ~rst;
  assign fetch_branch_target = (taken_c & ~rst) ? target_c : '0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (if_id_flush && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; two instances cover LU_STALL_CYCLES of 1 and 3.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] IDL = 6'b000000;
  localparam logic [5:0] FRZ = 6'b110100; // {pc,ifs,iff,ids,idf,bt}
  localparam logic [5:0] LUS = 6'b110010;
  localparam logic [5:0] RDR = 6'b001011;
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_SC = 32'd4;
  localparam logic [31:0] EXP_FE = 32'd1;
`else
  localparam logic [31:0] EXP_SC = 32'd0;
  localparam logic [31:0] EXP_FE = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read;
  logic br_valid, br_taken, mem_busy;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [63:0] br_target;

  logic pc1, ifs1, iff1, ids1, idf1, bt1;
  logic pc3, ifs3, iff3, ids3, idf3, bt3;
  logic [63:0] tgt1, tgt3;
  logic [31:0] sc1, fe1, sc3, fe3;
  logic [5:0] ctl1, ctl3;

  int n_cmp = 0;
  int n_err = 0;

  assign ctl1 = {pc1, ifs1, iff1, ids1, idf1, bt1};
  assign ctl3 = {pc3, ifs3, iff3, ids3, idf3, bt3};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.XLEN(64), .LU_STALL_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .mem_busy(mem_busy), .pc_stall(pc1), .if_id_stall(ifs1),
    .if_id_flush(iff1), .id_ex_stall(ids1), .id_ex_flush(idf1),
    .fetch_branch_taken(bt1), .fetch_branch_target(tgt1),
    .stall_cycles(sc1), .flush_events(fe1));

  pipeline_hazard_ctrl #(.XLEN(64), .LU_STALL_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .mem_busy(mem_busy), .pc_stall(pc3), .if_id_stall(ifs3),
    .if_id_flush(iff3), .id_ex_stall(ids3), .id_ex_flush(idf3),
    .fetch_branch_taken(bt3), .fetch_branch_target(tgt3),
    .stall_cycles(sc3), .flush_events(fe3));

  task automatic clr_in();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_valid = 0; ex_mem_read = 0;
    br_valid = 0; br_taken = 0; mem_busy = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; br_target = 0;
  endtask

  task automatic hazard();
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd5;
    id_valid = 1; id_rs1 = 5'd5; id_uses_rs1 = 1; id_rs2 = 5'd7;
  endtask

  task automatic branch(input logic [63:0] t);
    br_valid = 1; br_taken = 1; br_target = t;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; clr_in();
    @(negedge clk); rst = 0;
    next_cyc();
  endtask

  task automatic test_reset();
    clr_in(); hazard(); branch(64'h1234); rst = 1;
    @(negedge clk);
    n_cmp++; if (ctl1 !== IDL) begin n_err++; $display("FAIL rst_ctl1: got %b want %b", ctl1, IDL); end
    n_cmp++; if (ctl3 !== IDL) begin n_err++; $display("FAIL rst_ctl3: got %b want %b", ctl3, IDL); end
    n_cmp++; if (tgt1 !== 64'h0) begin n_err++; $display("FAIL rst_tgt: got %h want 0", tgt1); end
    n_cmp++; if (sc1 !== 32'd0 || fe1 !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", sc1, fe1); end
    clr_in(); rst = 0;
    next_cyc();
  endtask

  task automatic test_load_use();
    hazard();
    @(negedge clk);
    n_cmp++; if (ctl1 !== LUS) begin n_err++; $display("FAIL lu1_c1: got %b want %b", ctl1, LUS); end
    next_cyc(); clr_in();
    @(negedge clk);
    n_cmp++; if (ctl1 !== IDL) begin n_err++; $display("FAIL lu1_c2: got %b want %b", ctl1, IDL); end
    next_cyc();
    // rs2 path
    hazard(); id_uses_rs1 = 0; id_rs2 = 5'd5; id_uses_rs2 = 1;
    @(negedge clk);
    n_cmp++; if (ctl1 !== LUS) begin n_err++; $display("FAIL lu1_rs2: got %b want %b", ctl1, LUS); end
    next_cyc(); clr_in(); next_cyc();
  endtask

  task automatic test_no_hazard();
    hazard(); ex_rd = 5'd0; id_rs1 = 5'd0;
    @(negedge clk);
    n_cmp++; if (ctl1 !== IDL) begin n_err++; $display("FAIL nohz_rd0: got %b want %b", ctl1, IDL); end
    next_cyc();
    hazard(); id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs2 = 5'd5;
    @(negedge clk);
    n_cmp++; if (ctl1 !== IDL) begin n_err++; $display("FAIL nohz_uses: got %b want %b", ctl1, IDL); end
    next_cyc();
    hazard(); ex_mem_read = 0;
    @(negedge clk);
    n_cmp++; if (ctl3 !== IDL) begin n_err++; $display("FAIL nohz_noload: got %b want %b", ctl3, IDL); end
    next_cyc(); clr_in(); next_cyc();
  endtask

  task automatic test_lu_multi();
    hazard();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (ctl3 !== LUS) begin n_err++; $display("FAIL lu3_c%0d: got %b want %b", i + 1, ctl3, LUS); end
      next_cyc(); clr_in();
    end
    @(negedge clk);
    n_cmp++; if (ctl3 !== IDL) begin n_err++; $display("FAIL lu3_end: got %b want %b", ctl3, IDL); end
    next_cyc();
    hazard();
    @(negedge clk);
    n_cmp++; if (ctl3 !== LUS) begin n_err++; $display("FAIL lu3br_c1: got %b want %b", ctl3, LUS); end
    next_cyc(); clr_in(); branch(64'h3000);
    @(negedge clk);
    n_cmp++; if (ctl3 !== RDR) begin n_err++; $display("FAIL lu3br_c2: got %b want %b", ctl3, RDR); end
    n_cmp++; if (tgt3 !== 64'h3000) begin n_err++; $display("FAIL lu3br_tgt: got %h want 3000", tgt3); end
    next_cyc(); clr_in();
    @(negedge clk);
    n_cmp++; if (ctl3 !== IDL) begin n_err++; $display("FAIL lu3br_c3: got %b want %b", ctl3, IDL); end
    next_cyc();
  endtask

  task automatic test_lu_and_branch();
    hazard(); branch(64'h1000);
    @(negedge clk);
    n_cmp++; if (ctl1 !== RDR) begin n_err++; $display("FAIL lubr_ctl: got %b want %b", ctl1, RDR); end
    n_cmp++; if (tgt1 !== 64'h1000) begin n_err++; $display("FAIL lubr_tgt: got %h want 1000", tgt1); end
    n_cmp++; if (pc1 !== 1'b0) begin n_err++; $display("FAIL lubr_pc: got %b want 0", pc1); end
    next_cyc(); clr_in();
    @(negedge clk);
    n_cmp++; if (ctl1 !== IDL) begin n_err++; $display("FAIL lubr_after: got %b want %b", ctl1, IDL); end
    next_cyc();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clr_in(); mem_busy = 1;
      if (i == 1) branch(64'h2000);
      @(negedge clk);
      n_cmp++; if (ctl1 !== FRZ) begin n_err++; $display("FAIL mw_c%0d: got %b want %b", i + 1, ctl1, FRZ); end
      next_cyc();
    end
    clr_in();
    @(negedge clk);
    n_cmp++; if (ctl1 !== RDR) begin n_err++; $display("FAIL mw_redir: got %b want %b", ctl1, RDR); end
    n_cmp++; if (tgt1 !== 64'h2000) begin n_err++; $display("FAIL mw_tgt: got %h want 2000", tgt1); end
    next_cyc();
    @(negedge clk);
    n_cmp++; if (ctl1 !== IDL || tgt1 !== 64'h0) begin n_err++; $display("FAIL mw_after: got %b/%h want %b/0", ctl1, tgt1, IDL); end
    n_cmp++; if (sc1 !== EXP_SC) begin n_err++; $display("FAIL cnt_stall: got %0d want %0d", sc1, EXP_SC); end
    n_cmp++; if (fe1 !== EXP_FE) begin n_err++; $display("FAIL cnt_flush: got %0d want %0d", fe1, EXP_FE); end
    next_cyc();
  endtask

  task automatic test_back_to_back();
    mem_busy = 1; branch(64'h5000);
    next_cyc();
    mem_busy = 1; branch(64'h6000);
    @(negedge clk);
    n_cmp++; if (bt1 !== 1'b0 || ctl1 !== FRZ) begin n_err++; $display("FAIL b2b_frz: got %b want %b", ctl1, FRZ); end
    next_cyc(); clr_in();
    @(negedge clk);
    n_cmp++; if (tgt1 !== 64'h6000 || ctl1 !== RDR) begin n_err++; $display("FAIL b2b_last: got %b/%h want %b/6000", ctl1, tgt1, RDR); end
    next_cyc();
    @(negedge clk);
    n_cmp++; if (ctl1 !== IDL) begin n_err++; $display("FAIL b2b_after: got %b want %b", ctl1, IDL); end
    next_cyc();
  endtask

  task automatic test_lu_in_memwait();
    hazard();
    @(negedge clk);
    n_cmp++; if (ctl3 !== LUS) begin n_err++; $display("FAIL lumw_c1: got %b want %b", ctl3, LUS); end
    next_cyc(); clr_in(); mem_busy = 1;
    @(negedge clk);
    n_cmp++; if (ctl3 !== FRZ) begin n_err++; $display("FAIL lumw_c2: got %b want %b", ctl3, FRZ); end
    next_cyc();
    @(negedge clk);
    n_cmp++; if (ctl3 !== FRZ) begin n_err++; $display("FAIL lumw_c3: got %b want %b", ctl3, FRZ); end
    next_cyc(); mem_busy = 0;
    @(negedge clk);
    n_cmp++; if (ctl3 !== LUS) begin n_err++; $display("FAIL lumw_c4: got %b want %b", ctl3, LUS); end
    next_cyc();
    @(negedge clk);
    n_cmp++; if (ctl3 !== LUS) begin n_err++; $display("FAIL lumw_c5: got %b want %b", ctl3, LUS); end
    next_cyc();
    @(negedge clk);
    n_cmp++; if (ctl3 !== IDL) begin n_err++; $display("FAIL lumw_c6: got %b want %b", ctl3, IDL); end
    next_cyc();
  endtask

  task automatic test_reset_mid_memwait();
    mem_busy = 1; branch(64'h4000);
    next_cyc();
    clr_in(); mem_busy = 1;
    #2 rst = 1;
    #1;
    n_cmp++; if (ctl1 !== IDL || tgt1 !== 64'h0) begin n_err++; $display("FAIL rstmw_out: got %b/%h want %b/0", ctl1, tgt1, IDL); end
    n_cmp++; if (sc1 !== 32'd0 || fe1 !== 32'd0) begin n_err++; $display("FAIL rstmw_cnt: got %0d/%0d want 0/0", sc1, fe1); end
    @(negedge clk); clr_in(); rst = 0;
    next_cyc();
    @(negedge clk);
    n_cmp++; if (ctl1 !== IDL || bt1 !== 1'b0) begin n_err++; $display("FAIL rstmw_nopend: got %b want %b", ctl1, IDL); end
    n_cmp++; if (ctl3 !== IDL) begin n_err++; $display("FAIL rstmw_nopend3: got %b want %b", ctl3, IDL); end
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_in();
    rst = 1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_lu_multi();
    test_lu_and_branch();
    test_mem_wait();
    test_back_to_back();
    test_lu_in_memwait();
    test_reset_mid_memwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
